// File: rtl/param_command_fifo.sv
// param_command_fifo
//   Parameterised synchronous command FIFO. It has occupancy flags, sticky
//   error flags and a selectable read style:
//     FWFT = 0 : registered read. A popped word shows on Data_out one cycle
//                after the accepted read, and Data_valid pulses for that cycle.
//     FWFT = 1 : first-word-fall-through. The head word is always shown while
//                the FIFO is not empty, and Data_valid == !Out_Busy.
//
// Handshake: a write is taken at a rising clk edge when wr_en is high and
//   either the FIFO is not full or a read is taken in the same cycle. A read
//   is taken when rd_en is high and the FIFO is not empty. A request that is
//   not taken changes no state, apart from setting its sticky error flag.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   wr_en, Data_in      write request and write data
//   rd_en               read / pop request
//   Data_out            read data
//   Data_valid          Data_out holds a valid popped word or head word
//   In_Busy, Out_Busy   full, empty
//   Almost_full         Count >= AF_LEVEL
//   Almost_empty        Count <= AE_LEVEL
//   Count               occupancy, 0..DEPTH
//   Overflow/Underflow  sticky flags for rejected writes / rejected reads
//   Clr_err             synchronous clear of the sticky flags
module param_command_fifo #(
    parameter int Data     = 4,
    parameter int Adbus    = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [Data-1:0]   Data_in,
    output logic [Data-1:0]   Data_out,
    output logic              Data_valid,
    output logic              In_Busy,
    output logic              Out_Busy,
    output logic              Almost_full,
    output logic              Almost_empty,
    output logic [Adbus:0]    Count,
    output logic              Overflow,
    output logic              Underflow,
    input  logic              Clr_err
);

    localparam int             DEPTH   = 1 << Adbus;
    localparam logic [Adbus:0] DEPTH_C = (Adbus+1)'(DEPTH);
    localparam logic [Adbus:0] AF_C    = (Adbus+1)'(AF_LEVEL);
    localparam logic [Adbus:0] AE_C    = (Adbus+1)'(AE_LEVEL);

    logic [Data-1:0]  mem [DEPTH];
    logic [Adbus-1:0] wr_addr;
    logic [Adbus-1:0] rd_addr;
    logic [Adbus:0]   count_q;
    logic             rd_acc;
    logic             wr_acc;

    // All flags are decoded from the registered count, so they change in the
    // same cycle that Count changes.
    assign Count        = count_q;
    assign In_Busy      = (count_q == DEPTH_C);
    assign Out_Busy     = (count_q == '0);
    assign Almost_full  = (count_q >= AF_C);
    assign Almost_empty = (count_q <= AE_C);

    // A full FIFO can still take a write when a pop frees a slot in the
    // same cycle.
    assign rd_acc = rd_en && !Out_Busy;
    assign wr_acc = wr_en && (!In_Busy || rd_acc);

    // The storage has no reset. After a reset the pointers and the count
    // are zero, so any stale words cannot be reached.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= Data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            count_q   <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_addr <= wr_addr + 1'b1;
            if (rd_acc) rd_addr <= rd_addr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A new error in this cycle wins over a clear in the same cycle.
            if (wr_en && !wr_acc)  Overflow <= 1'b1;
            else if (Clr_err)      Overflow <= 1'b0;
            if (rd_en && !rd_acc)  Underflow <= 1'b1;
            else if (Clr_err)      Underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Show zero while empty, so the output after reset is zero.
            assign Data_out   = Out_Busy ? '0 : mem[rd_addr];
            assign Data_valid = !Out_Busy;
        end else begin : g_registered
            logic [Data-1:0] dout_q;
            logic            dvalid_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q   <= '0;
                    dvalid_q <= 1'b0;
                end else begin
                    dvalid_q <= rd_acc;
                    if (rd_acc) dout_q <= mem[rd_addr];
                end
            end
            assign Data_out   = dout_q;
            assign Data_valid = dvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_command_fifo.sv
// tb_param_command_fifo
//   Drives the same stimulus into two instances, one in registered-read mode
//   and one in FWFT mode. After each clock edge it compares every output with
//   a queue-based reference model.
module tb_param_command_fifo;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] r_dout,  f_dout;
    logic          r_dv,    f_dv;
    logic          r_inb,   f_inb;
    logic          r_outb,  f_outb;
    logic          r_af,    f_af;
    logic          r_ae,    f_ae;
    logic [AW:0]   r_cnt,   f_cnt;
    logic          r_ovf,   f_ovf;
    logic          r_udf,   f_udf;

    param_command_fifo #(.Data(DW), .Adbus(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .Data_in(data_in),
        .Data_out(r_dout), .Data_valid(r_dv), .In_Busy(r_inb), .Out_Busy(r_outb),
        .Almost_full(r_af), .Almost_empty(r_ae), .Count(r_cnt),
        .Overflow(r_ovf), .Underflow(r_udf), .Clr_err(clr_err)
    );

    param_command_fifo #(.Data(DW), .Adbus(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .Data_in(data_in),
        .Data_out(f_dout), .Data_valid(f_dv), .In_Busy(f_inb), .Out_Busy(f_outb),
        .Almost_full(f_af), .Almost_empty(f_ae), .Count(f_cnt),
        .Overflow(f_ovf), .Underflow(f_udf), .Clr_err(clr_err)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_dout0;
    logic          m_dv0;
    logic          m_ovf;
    logic          m_udf;
    int            total = 0;
    int            bad   = 0;

    task automatic model_reset();
        exp_q.delete();
        m_dout0 = '0;
        m_dv0   = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // Applies one clock edge of the FIFO rules to the model.
    task automatic model_edge(input logic wr, input logic rd, input logic [DW-1:0] din, input logic clr);
        logic racc, wacc;
        racc = rd && (exp_q.size() > 0);
        wacc = wr && ((exp_q.size() < DEPTH) || racc);
        m_dv0 = racc;
        if (racc) m_dout0 = exp_q.pop_front();
        if (wacc) exp_q.push_back(din);
        if (wr && !wacc)   m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (rd && !racc)   m_udf = 1'b1;
        else if (clr)      m_udf = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = exp_q.size();
        check({tag, " cnt"},     32'(r_cnt),  32'(n));
        check({tag, " in_busy"}, 32'(r_inb),  32'(n == DEPTH));
        check({tag, " out_busy"},32'(r_outb), 32'(n == 0));
        check({tag, " af"},      32'(r_af),   32'(n >= AF));
        check({tag, " ae"},      32'(r_ae),   32'(n <= AE));
        check({tag, " ovf"},     32'(r_ovf),  32'(m_ovf));
        check({tag, " udf"},     32'(r_udf),  32'(m_udf));
        check({tag, " dout0"},   32'(r_dout), 32'(m_dout0));
        check({tag, " dv0"},     32'(r_dv),   32'(m_dv0));
        check({tag, " f_cnt"},   32'(f_cnt),  32'(n));
        check({tag, " f_ovf"},   32'(f_ovf),  32'(m_ovf));
        check({tag, " f_udf"},   32'(f_udf),  32'(m_udf));
        check({tag, " f_dv"},    32'(f_dv),   32'(n != 0));
        check({tag, " f_dout"},  32'(f_dout), (n != 0) ? 32'(exp_q[0]) : 32'd0);
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1: drive the inputs, take one edge, then check.
    task automatic step(input string tag, input logic wr, input logic rd,
                        input logic [DW-1:0] din, input logic clr);
        wr_en = wr; rd_en = rd; data_in = din; clr_err = clr;
        @(posedge clk);
        model_edge(wr, rd, din, clr);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset");

        // Fill to full, then drain. Almost_full is set from the 6th write on.
        for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
        check("full_inb", 32'(r_inb), 32'd1);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
        check("drain_last", 32'(r_dout), 32'h18);

        // Overflow, then a write and a read together while full, then clear.
        for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
        step("ovf", 1'b1, 1'b0, 8'h99, 1'b0);
        check("ovf_set", 32'(r_ovf), 32'd1);
        step("full_rw", 1'b1, 1'b1, 8'hAA, 1'b0);
        check("full_rw_pop", 32'(r_dout), 32'h11);
        step("clr", 1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_clr", 32'(r_ovf), 32'd0);
        for (int i = 0; i < 8; i++) step("drain2", 1'b0, 1'b1, 8'h00, 1'b0);
        check("aa_last", 32'(r_dout), 32'hAA);

        // Underflow, then a write and a read together while empty.
        step("udf", 1'b0, 1'b1, 8'h00, 1'b0);
        step("empty_rw", 1'b1, 1'b1, 8'h5A, 1'b0);
        check("udf_hold", 32'(r_udf), 32'd1);
        step("pop5a", 1'b0, 1'b1, 8'h00, 1'b1);
        // A new underflow in the same cycle as a clear keeps the flag set.
        step("udf_vs_clr", 1'b0, 1'b1, 8'h00, 1'b1);
        check("udf_prio", 32'(r_udf), 32'd1);
        step("clr2", 1'b0, 1'b0, 8'h00, 1'b1);

        // Pointer wrap: 20 write/read pairs.
        for (int i = 0; i < 20; i++) begin
            step("wrap_w", 1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
            step("wrap_r", 1'b0, 1'b1, 8'h00, 1'b0);
        end

        // FWFT: a word written into an empty FIFO shows on the next cycle.
        step("fwft_w", 1'b1, 1'b0, 8'h3C, 1'b0);
        check("fwft_head", 32'(f_dout), 32'h3C);
        step("fwft_r", 1'b0, 1'b1, 8'h00, 1'b0);
        check("fwft_empty", 32'(f_outb), 32'd1);

        // Reset in the middle of operation, asserted between clock edges.
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        step("inflight_rd", 1'b0, 1'b1, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_release");
        step("post_rst_w", 1'b1, 1'b0, 8'hE1, 1'b0);
        step("post_rst_r", 1'b0, 1'b1, 8'h00, 1'b0);
        check("no_old_data", 32'(r_dout), 32'hE1);

        // Random traffic: write-heavy, then read-heavy, so that both full
        // and empty are reached.
        for (int i = 0; i < 400; i++) begin
            logic w, r, c;
            if ((i / 100) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            c = ($urandom_range(0, 15) == 0);
            step("rand", w, r, 8'($urandom_range(0, 255)), c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Stop the run if it somehow stalls.
    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
